muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M op encoding and FSM state type for the iterative mul/div unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide, one bit per cycle via shift-add and restoring division,
// with sign handled by magnitude pre-correction and result post-negation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    muldiv_state_t  r_state, w_next;
    muldiv_op_t     r_op;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic           r_neg;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_result;

    logic           w_accept, w_is_div, w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_last;
    logic [W-1:0]   w_a_mag, w_b_mag, w_spec_res, w_final;
    logic [W:0]     w_sum, w_shift, w_diff;
    logic [2*W-1:0] w_mul_next, w_div_next, w_step, w_prod_fix;

    assign ready  = r_state != S_BUSY;
    assign busy   = r_state == S_BUSY;
    assign done   = r_state == S_DONE;
    assign result = r_result;

    assign w_accept  = start & ready & ~flush;
    assign w_is_div  = op[2];
    assign w_a_neg   = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) & src_a[W-1];
    assign w_b_neg   = (op == OP_MULH || op == OP_DIV || op == OP_REM) & src_b[W-1];
    assign w_a_mag   = w_a_neg ? -src_a : src_a;
    assign w_b_mag   = w_b_neg ? -src_b : src_b;
    assign w_div0    = w_is_div && src_b == '0;
    assign w_ovf     = (op == OP_DIV || op == OP_REM) && src_a == {1'b1, {(W-1){1'b0}}} && &src_b;
    assign w_special = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);

    // Product register: upper half accumulates, multiplier shifts out of the low end.
    assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
    // Division register: {remainder, dividend/quotient}, quotient bits enter at the bottom.
    assign w_shift    = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_div_next = w_diff[W] ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                  : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
    assign w_step     = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod_fix = r_neg ? -w_step : w_step;
    assign w_final    = r_op[2] ? (r_op[1] ? (r_neg ? -w_step[2*W-1:W] : w_step[2*W-1:W])
                                           : (r_neg ? -w_step[W-1:0] : w_step[W-1:0]))
                                : (r_op[1:0] == 2'b00 ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W]);
    assign w_last     = r_cnt == CNT_WIDTH'(1);

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = S_IDLE;
        else if (r_state == S_BUSY)
            w_next = w_last ? S_DONE : S_BUSY;
        else if (w_accept)
            w_next = w_special ? S_DONE : S_BUSY;
        else
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= CNT_WIDTH'(W);
                if (w_special)
                    r_result <= w_spec_res;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
                if (w_last && !flush)
                    r_result <= w_final;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= muldiv_op_t'(op);
            r_neg <= (w_is_div && op[1]) ? w_a_neg : w_a_neg ^ w_b_neg;
            r_b   <= w_is_div ? w_b_mag : w_a_mag;
            r_acc <= {{W{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
        end else if (r_state == S_BUSY) begin
            r_acc <= w_step;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, flush, reset and back-to-back.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        ready, busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int lat, bcnt, dcnt;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nb++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input int el);
        int n, nb;
        issue(o, a, b);
        wait_done(n, nb);
        chk({tag, "_res"}, result, er);
        chk({tag, "_lat"}, n, el);
    endtask

    task automatic idle_cycles(input int k, output int nd);
        nd = 0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
    endtask

    initial begin
        int n, nb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'b000, 32'd7, 32'hFFFFFFFD);
        wait_done(n, nb);
        chk("mul_res", result, 32'hFFFFFFEB);
        chk("mul_lat", n, 33);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_done_ready", ready, 1);
        @(posedge clk);
        #1;
        chk("mul_done_pulse", done, 0);
        chk("mul_hold", result, 32'hFFFFFFEB);

        run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run("div_nd", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run("rem_nd", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
        run("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
        run("remu",   3'b111, 32'd100, 32'd7, 32'd2, 33);
        run("divu0",  3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run("rem0",   3'b110, 32'd5, 32'd0, 32'd5, 1);
        run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // Flush ten cycles into a division: back to idle, no done, result untouched.
        issue(3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_busy", busy, 0);
        idle_cycles(40, n);
        chk("flush_no_done", n, 0);
        chk("flush_result", result, 32'd0);

        // A start pulse while busy must not disturb the running op.
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b000; src_a = 32'd1; src_b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, nb);
        chk("ign_res", result, 32'hFFFFFFFE);
        chk("ign_lat", n + 5, 33);

        // Reset mid-operation.
        issue(3'b000, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_ready", ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(40, n);
        chk("mrst_no_done", n, 0);

        // Back-to-back: second start held during the first done cycle.
        issue(3'b101, 32'd100, 32'd7);
        wait_done(n, nb);
        chk("b2b_first", result, 32'd14);
        @(negedge clk);
        start = 1'b1; op = 3'b111; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_hold", result, 32'd14);
        wait_done(dcnt, bcnt);
        chk("b2b_second", result, 32'd2);
        chk("b2b_lat", dcnt + 10, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
